// File: rtl/aes_block_collector.sv
// Collects the core's byte-serial output stream into 128-bit blocks and
// queues them in a small register FIFO for a valid/ready host consumer.
module aes_block_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK_I,
    input  logic             RESET_N_I,
    input  logic             CE_I,
    input  logic             CLR_I,
    input  logic [7:0]       BYTE_I,
    input  logic             BYTE_VALID_I,
    output logic [127:0]     BLOCK_O,
    output logic             BLOCK_VALID_O,
    input  logic             BLOCK_READY_I,
    output logic [CNT_W-1:0] COUNT_O,
    output logic             OVERFLOW_O
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]         idx;
    logic [14:0][7:0]   partial;
    logic [127:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    logic               capture;
    logic               push_req;
    logic               pop;
    logic               full;
    logic               push;
    logic [127:0]       assembled;

    // A full FIFO still accepts a new block when the head leaves on the same edge.
    always_comb begin
        capture   = CE_I & ~CLR_I & BYTE_VALID_I;
        push_req  = capture & (idx == 4'd15);
        pop       = CE_I & ~CLR_I & (count != '0) & BLOCK_READY_I;
        full      = (count == CNT_W'(DEPTH));
        push      = push_req & (~full | pop);
        assembled = {BYTE_I, partial};
    end

    always_ff @(posedge CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            idx     <= '0;
            partial <= '0;
        end else if (CE_I) begin
            if (CLR_I) begin
                idx <= '0;
            end else if (capture) begin
                idx <= idx + 4'd1;
                if (idx != 4'd15) begin
                    partial[idx] <= BYTE_I;
                end
            end
        end
    end

    // Storage is cleared on reset so the head output is never unknown.
    always_ff @(posedge CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= assembled;
        end
    end

    always_ff @(posedge CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (CE_I) begin
            if (CLR_I) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (push_req & ~push) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign BLOCK_O       = mem[rd_ptr];
    assign BLOCK_VALID_O = (count != '0);
    assign COUNT_O       = count;
    assign OVERFLOW_O    = overflow;

endmodule

// File: tb/tb_aes_block_collector.sv
// Directed bench for aes_block_collector: stimulus queues expected blocks,
// an independent monitor compares every popped block against that queue.
module tb_aes_block_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             ce;
    logic             clr;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic [127:0]     block;
    logic             block_valid;
    logic             block_ready;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic [127:0]     exp_q [$];
    int               checks;
    int               errors;

    aes_block_collector #(.DEPTH(DEPTH)) dut (
        .CLK_I         (clk),
        .RESET_N_I     (rst_n),
        .CE_I          (ce),
        .CLR_I         (clr),
        .BYTE_I        (byte_in),
        .BYTE_VALID_I  (byte_valid),
        .BLOCK_O       (block),
        .BLOCK_VALID_O (block_valid),
        .BLOCK_READY_I (block_ready),
        .COUNT_O       (count),
        .OVERFLOW_O    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after a rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [127:0] expBlock(input logic [7:0] base);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) begin
            b[8*k +: 8] = base + 8'(k);
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic sendBytes(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(base + 8'(k));
        end
    endtask

    task automatic popCycles(input int n);
        block_ready = 1'b1;
        repeat (n) tick();
        block_ready = 1'b0;
    endtask

    task automatic checkState(input string name, input int exp_count, input logic exp_ovf);
        checkOutput({name, "_count"}, 128'(count), 128'(exp_count));
        checkOutput({name, "_valid"}, 128'(block_valid), 128'(exp_count != 0));
        checkOutput({name, "_ovf"}, 128'(overflow), 128'(exp_ovf));
    endtask

    // Monitor: every edge that will pop a block is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && ce && !clr && block_valid && block_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL pop_unexpected: got %h expected no block", block);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (block !== e) begin
                    errors++;
                    $display("[TB] FAIL pop_block: got %h expected %h", block, e);
                end
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        ce          = 1'b1;
        clr         = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        block_ready = 1'b0;
        repeat (2) tick();
        checkState("reset", 0, 1'b0);
        checkOutput("reset_block", block, 128'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] basic block assembly");
        exp_q.push_back(expBlock(8'h00));
        sendBytes(8'h00, 16);
        checkState("t1_after", 1, 1'b0);
        checkOutput("t1_block", block, 128'h0F0E0D0C0B0A09080706050403020100);
        popCycles(1);
        checkState("t1_drained", 0, 1'b0);

        $display("[TB] gaps and clock-enable hold");
        exp_q.push_back(expBlock(8'h00));
        sendBytes(8'h00, 7);
        repeat (3) tick();
        ce = 1'b0;
        applyStimulus(8'hFF);
        ce = 1'b1;
        sendBytes(8'h07, 9);
        checkState("t2_after", 1, 1'b0);
        checkOutput("t2_block", block, 128'h0F0E0D0C0B0A09080706050403020100);
        popCycles(1);

        $display("[TB] overflow and realignment");
        for (int n = 0; n < 5; n++) begin
            if (n < DEPTH) exp_q.push_back(expBlock(8'(16 * n)));
            sendBytes(8'(16 * n), 16);
        end
        checkState("t3_full", 4, 1'b1);
        popCycles(4);
        checkState("t3_drained", 0, 1'b1);
        exp_q.push_back(expBlock(8'h50));
        sendBytes(8'h50, 16);
        checkOutput("t3_aligned", block, 128'h5F5E5D5C5B5A59585756555453525150);
        popCycles(1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkState("t3_cleared", 0, 1'b0);

        $display("[TB] simultaneous push and pop when full");
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back(expBlock(8'(8'h40 + 16 * n)));
            sendBytes(8'(8'h40 + 16 * n), 16);
        end
        checkState("t4_full", 4, 1'b0);
        exp_q.push_back(expBlock(8'h80));
        sendBytes(8'h80, 15);
        block_ready = 1'b1;
        applyStimulus(8'h8F);
        block_ready = 1'b0;
        checkState("t4_same_edge", 4, 1'b0);
        popCycles(4);
        checkState("t4_drained", 0, 1'b0);

        $display("[TB] clear mid-block");
        for (int n = 0; n < 5; n++) begin
            sendBytes(8'(16 * n), 16);
        end
        sendBytes(8'h11, 9);
        clr         = 1'b1;
        block_ready = 1'b1;
        applyStimulus(8'h77);
        clr         = 1'b0;
        block_ready = 1'b0;
        checkState("t5_cleared", 0, 1'b0);
        exp_q.push_back(expBlock(8'hA0));
        sendBytes(8'hA0, 16);
        checkState("t5_after", 1, 1'b0);
        checkOutput("t5_block", block, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        popCycles(1);

        $display("[TB] asynchronous reset mid-block");
        sendBytes(8'hC0, 16);
        sendBytes(8'hD0, 16);
        sendBytes(8'hE0, 10);
        checkOutput("t6_pre_count", 128'(count), 128'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkState("t6_async", 0, 1'b0);
        checkOutput("t6_async_block", block, 128'h0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        exp_q.push_back(expBlock(8'hF0));
        sendBytes(8'hF0, 16);
        checkState("t6_after", 1, 1'b0);
        popCycles(1);
        checkState("t6_drained", 0, 1'b0);

        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
